router_channel_tx: RTL

ROUTER_CHANNEL_TX -- requirements
Module: router_channel_tx

---
 rtl/router_channel_tx_pkg.sv | 30 +++
 rtl/router_tx_credit_ctr.sv | 43 ++++
 rtl/router_channel_tx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/router_channel_tx_pkg.sv
// ============================================================================
// Module  : router_channel_tx_pkg
// Brief   : Shared router constants: channel field offsets, flow-control bit
//           positions, VC count and the transmit FSM state type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package router_channel_tx_pkg;

  localparam int c_num_vc     = 2;
  localparam int c_chan_w     = 69;
  localparam int c_ch_valid   = 0;
  localparam int c_ch_head    = 1;
  localparam int c_ch_tail    = 2;
  localparam int c_ch_vc      = 3;
  localparam int c_ch_pay_lsb = 4;
  localparam int c_ch_pay_w   = 64;
  localparam int c_ch_parity  = 68;
  localparam int c_fc_valid   = 0;
  localparam int c_fc_vc      = 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/router_tx_credit_ctr.sv
// ============================================================================
// Module  : router_tx_credit_ctr
// Brief   : Per-VC credit counter (0..buffer_size) with non-zero and
//           overflow (credit returned while already full) indications.
// Revision: 1.0
// ============================================================================
`default_nettype none

module router_tx_credit_ctr #(
  parameter  int buffer_size = 8,
  localparam int c_cnt_w     = $clog2(buffer_size + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic overflow
);

  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(buffer_size);

  logic [c_cnt_w-1:0] r_count;
  logic               w_full;

  assign w_full   = (r_count == c_full);
  assign nonzero  = (r_count != '0);
  // A return alongside a spend on the same VC nets to zero and is legal.
  assign overflow = inc && !dec && w_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= c_full;
    end else if (inc && !dec && !w_full) begin
      r_count <= r_count + 1'b1;
    end else if (dec && !inc) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/router_channel_tx.sv
// ============================================================================
// Module  : router_channel_tx
// Brief   : Credit-based two-VC router channel transmitter with sticky error.
//           Optional even parity in channel bit 68 via ROUTER_TX_PARITY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module router_channel_tx
  import router_channel_tx_pkg::*;
#(
  parameter int buffer_size     = 8,
  parameter int flit_data_width = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_head,
  input  logic                       in_tail,
  input  logic [flit_data_width-1:0] in_data,
  output logic [0:c_chan_w-1]        channel_out,
  input  logic [0:1]                 flow_ctrl_in,
  output logic                       error
);

  tx_state_t r_state, w_state_nxt;
  logic      r_cur_vc, w_cur_vc_nxt;
  logic      r_rr_last, w_rr_last_nxt;
  logic      w_rr_alt, w_rr_pick;
  logic      w_accept, w_send, w_send_vc, w_proto_err;

  logic [c_num_vc-1:0]   w_nonzero, w_overflow, w_inc, w_dec;
  logic [c_ch_pay_w-1:0] w_payload;
  logic [0:c_chan_w-1]   w_chan, r_chan;
  logic                  r_error;

  for (genvar v = 0; v < c_num_vc; v++) begin : g_vc
    assign w_inc[v] = flow_ctrl_in[c_fc_valid] && (flow_ctrl_in[c_fc_vc] == 1'(v));
    assign w_dec[v] = w_send && (w_send_vc == 1'(v));

    router_tx_credit_ctr #(
      .buffer_size(buffer_size)
    ) u_ctr (
      .clk     (clk),
      .reset   (reset),
      .inc     (w_inc[v]),
      .dec     (w_dec[v]),
      .nonzero (w_nonzero[v]),
      .overflow(w_overflow[v])
    );
  end

  assign in_ready = (r_state == ST_IDLE) ? (|w_nonzero) : w_nonzero[r_cur_vc];
  assign w_accept = in_valid && in_ready;

  // Round-robin: prefer the VC after the last one chosen, fall back if empty.
  assign w_rr_alt  = ~r_rr_last;
  assign w_rr_pick = w_nonzero[w_rr_alt] ? w_rr_alt : r_rr_last;

  always_comb begin
    w_state_nxt   = r_state;
    w_cur_vc_nxt  = r_cur_vc;
    w_rr_last_nxt = r_rr_last;
    w_send        = 1'b0;
    w_send_vc     = r_cur_vc;
    w_proto_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (in_head) begin
            w_send        = 1'b1;
            w_send_vc     = w_rr_pick;
            w_cur_vc_nxt  = w_rr_pick;
            w_rr_last_nxt = w_rr_pick;
            if (!in_tail) w_state_nxt = ST_ACTIVE;
          end else begin
            w_proto_err = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (w_accept) begin
          if (in_head) begin
            w_proto_err = 1'b1;
          end else begin
            w_send = 1'b1;
            if (in_tail) w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_payload = c_ch_pay_w'(in_data);

  always_comb begin
    w_chan              = '0;
    w_chan[c_ch_valid]  = 1'b1;
    w_chan[c_ch_head]   = in_head;
    w_chan[c_ch_tail]   = in_tail;
    w_chan[c_ch_vc]     = w_send_vc;
    for (int i = 0; i < c_ch_pay_w; i++) begin
      w_chan[c_ch_pay_lsb + i] = w_payload[i];
    end
`ifdef ROUTER_TX_PARITY_EN
    w_chan[c_ch_parity] = ^w_chan[0:c_ch_parity-1];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cur_vc  <= 1'b0;
      r_rr_last <= 1'b1;
      r_chan    <= '0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_vc  <= w_cur_vc_nxt;
      r_rr_last <= w_rr_last_nxt;
      r_chan    <= w_send ? w_chan : '0;
      r_error   <= r_error | w_proto_err | (|w_overflow);
    end
  end

  assign channel_out = r_chan;
  assign error       = r_error;

endmodule

`default_nettype wire
